// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry queue between IMEM and ID.
// Owns the fetch PC, buffers {inst, pc+4} entries while ID stalls, and
// applies branch/jump redirects with optional MIPS delay-slot retention.
module if_fetch_queue #(
    parameter int              DEPTH      = 4,
    parameter int              ADDR_W     = 32,
    parameter int              DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0040_0000,
    parameter bit              DELAY_SLOT = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     id_stall,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_inst,
    output logic [ADDR_W-1:0]        id_NPC,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_inst_mem [DEPTH];
    logic [ADDR_W-1:0] r_npc_mem  [DEPTH];

    logic [ADDR_W-1:0] w_fetch_pc_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [CNT_W-1:0]  w_count_next;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic              w_pop;
    logic              w_push;
    logic              w_redirect;

    // Head-entry view is driven from registers only, so ID handshake
    // inputs never reach these outputs combinationally.
    assign id_valid  = (r_count != '0);
    assign id_inst   = id_valid ? r_inst_mem[r_rd_ptr] : '0;
    assign id_NPC    = id_valid ? r_npc_mem[r_rd_ptr]  : '0;
    assign count     = r_count;
    assign imem_addr = r_fetch_pc;

    assign w_pc_plus4 = r_fetch_pc + ADDR_W'(4);
    assign w_pop      = id_valid & ~id_stall;
    // A redirect only counts when ID actually consumes the branch.
    assign w_redirect = redirect & w_pop;

    // Next-state for PC, pointers and occupancy; redirect overrides normal flow.
    always_comb begin
        w_push          = 1'b0;
        w_fetch_pc_next = r_fetch_pc;
        w_rd_ptr_next   = r_rd_ptr;
        w_wr_ptr_next   = r_wr_ptr;
        w_count_next    = r_count;
        if (w_redirect) begin
            w_fetch_pc_next = redirect_pc;
            if (!DELAY_SLOT) begin
                // Flush everything, including anything fetched past the branch.
                w_rd_ptr_next = r_wr_ptr;
                w_count_next  = '0;
            end else if (r_count >= CNT_W'(2)) begin
                // Delay slot is already queued right behind the head; drop the rest.
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
                w_wr_ptr_next = r_rd_ptr + PTR_W'(2);
                w_count_next  = CNT_W'(1);
            end else begin
                // Delay slot is the instruction being fetched right now.
                w_push        = 1'b1;
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
                w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
                w_count_next  = CNT_W'(1);
            end
        end else begin
            w_push = (r_count < CNT_W'(DEPTH)) | w_pop;
            if (w_push) begin
                w_wr_ptr_next   = r_wr_ptr + PTR_W'(1);
                w_fetch_pc_next = w_pc_plus4;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
            end
            w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Control state: cleared immediately by the asynchronous reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_fetch_pc_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_wr_ptr   <= w_wr_ptr_next;
            r_count    <= w_count_next;
        end
    end

    // Queue storage: write the current fetch into the tail slot on push.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= imem_data;
            r_npc_mem[r_wr_ptr]  <= w_pc_plus4;
        end
    end

endmodule
